fifo_ring: RTL

//  Synchronous single-clock FIFO built on a circular buffer. Replaces the shift-register FIFO.

---
 rtl/fifo_ring_pkg.sv | 6 +
 rtl/fifo_ram.sv | 24 ++
 rtl/fifo_ring.sv | 71 +++++++
 3 files changed

// File: rtl/fifo_ring_pkg.sv
// fifo_ring_pkg: shared default sizes and thresholds for the fifo_ring family
package fifo_ring_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_AE_THRESH = 1;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM with one write port and a registered, resettable read port
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_ring.sv
// fifo_ring: circular-buffer FIFO with registered read, occupancy count, threshold flags and error pulses
module fifo_ring import fifo_ring_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH = FIFO_DEPTH - 1,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int ADDR_W = $clog2(FIFO_DEPTH),
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_val,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_THRESH);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(FIFO_DEPTH - 1);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return p == LAST_C ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_ready = !reset && count != FULL_C;
    wr_acc = wr_en && wr_ready;
    rd_acc = rd_en && !reset && count != '0;
    almost_full = count >= AF_C;
    almost_empty = count <= AE_C;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rd_val <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_acc ? next_ptr(wr_ptr) : wr_ptr;
      rd_ptr <= rd_acc ? next_ptr(rd_ptr) : rd_ptr;
      count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      rd_val <= rd_acc;
      overflow <= wr_en && !wr_ready;
      underflow <= rd_en && count == '0;
    end
  end
  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk(clk),
    .reset(reset),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .re(rd_acc),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
endmodule
